// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction cache: FSM encoding and address-split helpers.
package cpu_pkg;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_REFILL = 1'b1;

    // Number of word-offset bits inside a line.
    function automatic int calcOff(input int lineWords);
        return $clog2(lineWords);
    endfunction

    // Tag bits left over once byte, word-offset and index bits are removed.
    function automatic int calcTagWidth(input int indexWidth, input int lineWords);
        return 30 - indexWidth - calcOff(lineWords);
    endfunction

endpackage

// File: rtl/inst_cache_assoc_if.sv
// Fetch-side and refill-side signals of the instruction cache, bundled.
interface inst_cache_assoc_if;

    logic        fetchValid;
    logic [31:0] addrIn;
    logic        hit;
    logic [31:0] dataOut;
    logic        flush;
    logic        memReq;
    logic [31:0] memAddr;
    logic        memValid;
    logic [31:0] memData;

    modport master (
        output fetchValid, addrIn, flush, memValid, memData,
        input  hit, dataOut, memReq, memAddr
    );

    modport slave (
        input  fetchValid, addrIn, flush, memValid, memData,
        output hit, dataOut, memReq, memAddr
    );

endinterface

// File: rtl/icache_way.sv
// One cache way: per-set valid bit (reset), tag and line storage (not reset).
module icache_way
    import cpu_pkg::*;
#(
    parameter int INDEX_WIDTH = 6,
    parameter int LINE_WORDS  = 4,
    localparam int OFF_W      = (calcOff(LINE_WORDS) > 0) ? calcOff(LINE_WORDS) : 1,
    localparam int TAG_WIDTH  = calcTagWidth(INDEX_WIDTH, LINE_WORDS)
) (
    input  logic                     clkIn,
    input  logic                     rstIn,
    input  logic                     flush_i,
    input  logic                     wrEn_i,
    input  logic [INDEX_WIDTH-1:0]   wrIndex_i,
    input  logic [TAG_WIDTH-1:0]     wrTag_i,
    input  logic [LINE_WORDS*32-1:0] wrLine_i,
    input  logic [INDEX_WIDTH-1:0]   rdIndex_i,
    input  logic [OFF_W-1:0]         rdOffset_i,
    output logic                     rdValid_o,
    output logic [TAG_WIDTH-1:0]     rdTag_o,
    output logic [31:0]              rdWord_o
);

    localparam int SETS = 1 << INDEX_WIDTH;

    logic [SETS-1:0]          valid_q;
    logic [TAG_WIDTH-1:0]     tagMem [SETS];
    logic [LINE_WORDS*32-1:0] lineMem [SETS];
    logic [LINE_WORDS*32-1:0] rdLine;

    // Valid bits: a flush wipes every set and takes priority over an install.
    always_ff @(posedge clkIn or negedge rstIn) begin
        if (!rstIn) begin
            valid_q <= '0;
        end else if (flush_i) begin
            valid_q <= '0;
        end else if (wrEn_i) begin
            valid_q[wrIndex_i] <= 1'b1;
        end
    end

    // Tag and line arrays are plain storage; validity is tracked separately.
    always_ff @(posedge clkIn) begin
        if (wrEn_i) begin
            tagMem[wrIndex_i]  <= wrTag_i;
            lineMem[wrIndex_i] <= wrLine_i;
        end
    end

    // Asynchronous lookup of the indexed set and selection of the requested word.
    always_comb begin
        rdValid_o = valid_q[rdIndex_i];
        rdTag_o   = tagMem[rdIndex_i];
        rdLine    = lineMem[rdIndex_i];
        rdWord_o  = '0;
        for (int i = 0; i < LINE_WORDS; i++) begin
            if (rdOffset_i == OFF_W'(i)) rdWord_o = rdLine[i*32 +: 32];
        end
    end

endmodule

// File: rtl/inst_cache_assoc.sv
// Set-associative (1 or 2 way) instruction cache with blocking line refill.
module inst_cache_assoc
    import cpu_pkg::*;
#(
    parameter int INDEX_WIDTH = 6,
    parameter int WAYS        = 2,
    parameter int LINE_WORDS  = 4
) (
    input  logic              clkIn,
    input  logic              rstIn,
    input  logic              rdyIn,
    inst_cache_assoc_if.slave bus
);

    localparam int OFF       = calcOff(LINE_WORDS);
    localparam int OFF_W     = (OFF > 0) ? OFF : 1;
    localparam int TAG_WIDTH = calcTagWidth(INDEX_WIDTH, LINE_WORDS);
    localparam int SETS      = 1 << INDEX_WIDTH;
    localparam int LINE_BITS = LINE_WORDS * 32;

    logic [0:0]           state_q, state_d;
    logic [31:0]          lineAddr_q, lineAddr_d;
    logic                 victim_q, victim_d;
    logic [OFF_W-1:0]     wordCnt_q, wordCnt_d;
    logic                 discard_q, discard_d;
    logic [LINE_BITS-1:0] refillBuf_q, refillBuf_d;

    logic [INDEX_WIDTH-1:0] reqIndex, fillIndex;
    logic [TAG_WIDTH-1:0]   reqTag, fillTag;
    logic [OFF_W-1:0]       reqOffset;
    logic [31:0]            reqBase;
    logic [WAYS-1:0]        wayValid, wayHit, wayWrEn;
    logic [TAG_WIDTH-1:0]   wayTag [WAYS];
    logic [31:0]            wayWord [WAYS];
    logic                   hitAny, hitWay, lruWay, victimSel;
    logic                   lastBeat, fillEn, flushAll;
    logic                   unusedBits;

    assign reqIndex   = bus.addrIn[INDEX_WIDTH+OFF+1:OFF+2];
    assign reqTag     = bus.addrIn[31:INDEX_WIDTH+OFF+2];
    assign reqBase    = {bus.addrIn[31:OFF+2], {(OFF+2){1'b0}}};
    assign fillIndex  = lineAddr_q[INDEX_WIDTH+OFF+1:OFF+2];
    assign fillTag    = lineAddr_q[31:INDEX_WIDTH+OFF+2];
    assign unusedBits = ^{bus.addrIn[1:0], lineAddr_q[OFF+1:0]};

    generate
        if (OFF > 0) begin : gOffset
            assign reqOffset = bus.addrIn[OFF+1:2];
        end else begin : gNoOffset
            assign reqOffset = 1'b0;
        end
    endgenerate

    assign lastBeat = (wordCnt_q == OFF_W'(LINE_WORDS - 1));
    assign fillEn   = rdyIn && (state_q == ST_REFILL) && bus.memValid && lastBeat
                      && !discard_q && !bus.flush;
    assign flushAll = rdyIn && bus.flush;

    generate
        for (genvar g = 0; g < WAYS; g++) begin : gWay
            assign wayWrEn[g] = fillEn && (int'(victim_q) == g);
            assign wayHit[g]  = wayValid[g] && (wayTag[g] == reqTag);
            icache_way #(
                .INDEX_WIDTH(INDEX_WIDTH),
                .LINE_WORDS (LINE_WORDS)
            ) uWay (
                .clkIn     (clkIn),
                .rstIn     (rstIn),
                .flush_i   (flushAll),
                .wrEn_i    (wayWrEn[g]),
                .wrIndex_i (fillIndex),
                .wrTag_i   (fillTag),
                .wrLine_i  (refillBuf_d),
                .rdIndex_i (reqIndex),
                .rdOffset_i(reqOffset),
                .rdValid_o (wayValid[g]),
                .rdTag_o   (wayTag[g]),
                .rdWord_o  (wayWord[g])
            );
        end
    endgenerate

    // Combine the per-way lookups into the hit flag, the hitting way and its word.
    always_comb begin
        hitAny = |wayHit;
        hitWay = 1'b0;
        bus.dataOut = wayWord[0];
        for (int w = 0; w < WAYS; w++) begin
            if (wayHit[w]) begin
                hitWay      = 1'(w);
                bus.dataOut = wayWord[w];
            end
        end
        bus.hit = (state_q == ST_IDLE) && bus.fetchValid && hitAny;
    end

    generate
        if (WAYS == 2) begin : gLru
            logic [SETS-1:0] lru_q;
            assign lruWay = lru_q[reqIndex];
            // Each hit or fill points the set's LRU bit at the way not just used.
            always_ff @(posedge clkIn or negedge rstIn) begin
                if (!rstIn) begin
                    lru_q <= '0;
                end else if (rdyIn) begin
                    if (bus.hit) begin
                        lru_q[reqIndex] <= ~hitWay;
                    end else if (fillEn) begin
                        lru_q[fillIndex] <= ~victim_q;
                    end
                end
            end
        end else begin : gNoLru
            assign lruWay = 1'b0;
        end
    endgenerate

    // Victim: lowest-numbered invalid way first, else whatever LRU names.
    always_comb begin
        victimSel = lruWay;
        if (!wayValid[0]) begin
            victimSel = 1'b0;
        end else if ((WAYS == 2) && !wayValid[WAYS-1]) begin
            victimSel = 1'b1;
        end
    end

    // Next-state logic for the IDLE/REFILL controller and the refill buffer.
    always_comb begin
        state_d     = state_q;
        lineAddr_d  = lineAddr_q;
        victim_d    = victim_q;
        wordCnt_d   = wordCnt_q;
        discard_d   = discard_q;
        refillBuf_d = refillBuf_q;
        case (state_q)
            ST_IDLE: begin
                if (!bus.flush && bus.fetchValid && !hitAny) begin
                    state_d    = ST_REFILL;
                    lineAddr_d = reqBase;
                    victim_d   = victimSel;
                    wordCnt_d  = '0;
                    discard_d  = 1'b0;
                end
            end
            ST_REFILL: begin
                if (bus.flush) discard_d = 1'b1;
                if (bus.memValid) begin
                    for (int i = 0; i < LINE_WORDS; i++) begin
                        if (wordCnt_q == OFF_W'(i)) refillBuf_d[i*32 +: 32] = bus.memData;
                    end
                    if (lastBeat) begin
                        state_d   = ST_IDLE;
                        wordCnt_d = '0;
                        discard_d = 1'b0;
                    end else begin
                        wordCnt_d = wordCnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control registers; everything holds while rdyIn is low.
    always_ff @(posedge clkIn or negedge rstIn) begin
        if (!rstIn) begin
            state_q    <= ST_IDLE;
            lineAddr_q <= '0;
            victim_q   <= 1'b0;
            wordCnt_q  <= '0;
            discard_q  <= 1'b0;
        end else if (rdyIn) begin
            state_q    <= state_d;
            lineAddr_q <= lineAddr_d;
            victim_q   <= victim_d;
            wordCnt_q  <= wordCnt_d;
            discard_q  <= discard_d;
        end
    end

    // Refill buffer is pure datapath and needs no reset.
    always_ff @(posedge clkIn) begin
        if (rdyIn) refillBuf_q <= refillBuf_d;
    end

    assign bus.memReq  = (state_q == ST_REFILL);
    assign bus.memAddr = lineAddr_q;

endmodule

// File: tb/tb_inst_cache_assoc.sv
// Directed bench for inst_cache_assoc: vector table plus flush, stall and reset sequences.
module tb_inst_cache_assoc;

    logic clkIn;
    logic rstIn;
    logic rdyIn;
    int   compared;
    int   mismatched;

    inst_cache_assoc_if cacheBus ();

    inst_cache_assoc #(
        .INDEX_WIDTH(4),
        .WAYS       (2),
        .LINE_WORDS (4)
    ) dut (
        .clkIn(clkIn),
        .rstIn(rstIn),
        .rdyIn(rdyIn),
        .bus  (cacheBus)
    );

    typedef struct {
        logic        fv;
        logic [31:0] addr;
        logic        mv;
        logic [31:0] md;
        logic        expHit;
        logic [31:0] expData;
        logic        expReq;
        logic        chkAddr;
        logic [31:0] expAddr;
    } vec_t;

    vec_t vecs[$];

    // Free-running clock, 10 time units per cycle.
    initial begin
        clkIn = 1'b0;
        forever #5 clkIn = ~clkIn;
    end

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic vec_t mkVec(input logic fv, input logic [31:0] addr, input logic mv,
                                   input logic [31:0] md, input logic expHit,
                                   input logic [31:0] expData, input logic expReq,
                                   input logic chkAddr, input logic [31:0] expAddr);
        vec_t v;
        v.fv = fv; v.addr = addr; v.mv = mv; v.md = md;
        v.expHit = expHit; v.expData = expData; v.expReq = expReq;
        v.chkAddr = chkAddr; v.expAddr = expAddr;
        return v;
    endfunction

    task automatic applyStimulus(input logic fv, input logic [31:0] addr, input logic fl,
                                 input logic mv, input logic [31:0] md, input logic rdy);
        @(negedge clkIn);
        cacheBus.fetchValid = fv;
        cacheBus.addrIn     = addr;
        cacheBus.flush      = fl;
        cacheBus.memValid   = mv;
        cacheBus.memData    = md;
        rdyIn               = rdy;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic checkHit(input string name, input logic expHit);
        checkOutput({name, " hit"}, {31'b0, cacheBus.hit}, {31'b0, expHit});
    endtask

    task automatic checkReq(input string name, input logic expReq);
        checkOutput({name, " memReq"}, {31'b0, cacheBus.memReq}, {31'b0, expReq});
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rstIn = 1'b0;
        rdyIn = 1'b1;
        cacheBus.fetchValid = 1'b0;
        cacheBus.addrIn     = '0;
        cacheBus.flush      = 1'b0;
        cacheBus.memValid   = 1'b0;
        cacheBus.memData    = '0;

        // Cold miss on 0x100, then hits; conflict fills of 0x500 and 0x900 in set 0.
        vecs.push_back(mkVec(0, 32'h000, 0, 32'h00, 0, 32'h00, 0, 1, 32'h000));
        vecs.push_back(mkVec(1, 32'h100, 0, 32'h00, 0, 32'h00, 0, 0, 32'h000));
        vecs.push_back(mkVec(0, 32'h000, 1, 32'hA0, 0, 32'h00, 1, 1, 32'h100));
        vecs.push_back(mkVec(0, 32'h000, 1, 32'hA1, 0, 32'h00, 1, 1, 32'h100));
        vecs.push_back(mkVec(0, 32'h000, 1, 32'hA2, 0, 32'h00, 1, 1, 32'h100));
        vecs.push_back(mkVec(0, 32'h000, 1, 32'hA3, 0, 32'h00, 1, 1, 32'h100));
        vecs.push_back(mkVec(1, 32'h108, 0, 32'h00, 1, 32'hA2, 0, 0, 32'h000));
        vecs.push_back(mkVec(1, 32'h100, 0, 32'h00, 1, 32'hA0, 0, 0, 32'h000));
        vecs.push_back(mkVec(1, 32'h10C, 0, 32'h00, 1, 32'hA3, 0, 0, 32'h000));
        vecs.push_back(mkVec(0, 32'h000, 1, 32'hDEADBEEF, 0, 32'h00, 0, 0, 32'h000));
        vecs.push_back(mkVec(1, 32'h104, 0, 32'h00, 1, 32'hA1, 0, 0, 32'h000));
        vecs.push_back(mkVec(1, 32'h500, 0, 32'h00, 0, 32'h00, 0, 0, 32'h000));
        vecs.push_back(mkVec(1, 32'h100, 1, 32'hB0, 0, 32'h00, 1, 1, 32'h500));
        vecs.push_back(mkVec(0, 32'h000, 1, 32'hB1, 0, 32'h00, 1, 1, 32'h500));
        vecs.push_back(mkVec(0, 32'h000, 1, 32'hB2, 0, 32'h00, 1, 1, 32'h500));
        vecs.push_back(mkVec(0, 32'h000, 1, 32'hB3, 0, 32'h00, 1, 1, 32'h500));
        vecs.push_back(mkVec(1, 32'h504, 0, 32'h00, 1, 32'hB1, 0, 0, 32'h000));
        vecs.push_back(mkVec(1, 32'h100, 0, 32'h00, 1, 32'hA0, 0, 0, 32'h000));
        vecs.push_back(mkVec(1, 32'h900, 0, 32'h00, 0, 32'h00, 0, 0, 32'h000));
        vecs.push_back(mkVec(0, 32'h000, 1, 32'hC0, 0, 32'h00, 1, 1, 32'h900));
        vecs.push_back(mkVec(0, 32'h000, 1, 32'hC1, 0, 32'h00, 1, 1, 32'h900));
        vecs.push_back(mkVec(0, 32'h000, 1, 32'hC2, 0, 32'h00, 1, 1, 32'h900));
        vecs.push_back(mkVec(0, 32'h000, 1, 32'hC3, 0, 32'h00, 1, 1, 32'h900));
        vecs.push_back(mkVec(1, 32'h908, 0, 32'h00, 1, 32'hC2, 0, 0, 32'h000));
        vecs.push_back(mkVec(1, 32'h100, 0, 32'h00, 1, 32'hA0, 0, 0, 32'h000));
        vecs.push_back(mkVec(1, 32'h500, 0, 32'h00, 0, 32'h00, 0, 0, 32'h000));
        vecs.push_back(mkVec(0, 32'h000, 1, 32'hD0, 0, 32'h00, 1, 1, 32'h500));
        vecs.push_back(mkVec(0, 32'h000, 1, 32'hD1, 0, 32'h00, 1, 1, 32'h500));
        vecs.push_back(mkVec(0, 32'h000, 1, 32'hD2, 0, 32'h00, 1, 1, 32'h500));
        vecs.push_back(mkVec(0, 32'h000, 1, 32'hD3, 0, 32'h00, 1, 1, 32'h500));
        vecs.push_back(mkVec(1, 32'h50C, 0, 32'h00, 1, 32'hD3, 0, 0, 32'h000));
        vecs.push_back(mkVec(1, 32'h100, 0, 32'h00, 1, 32'hA0, 0, 0, 32'h000));

        repeat (3) @(negedge clkIn);
        rstIn = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].fv, vecs[i].addr, 1'b0, vecs[i].mv, vecs[i].md, 1'b1);
            checkHit($sformatf("vec%0d", i), vecs[i].expHit);
            if (vecs[i].expHit)
                checkOutput($sformatf("vec%0d dataOut", i), cacheBus.dataOut, vecs[i].expData);
            checkReq($sformatf("vec%0d", i), vecs[i].expReq);
            if (vecs[i].chkAddr)
                checkOutput($sformatf("vec%0d memAddr", i), cacheBus.memAddr, vecs[i].expAddr);
        end

        // Flush in IDLE together with a miss: clears everything, starts no refill.
        applyStimulus(1, 32'h300, 1, 0, 32'h0, 1);
        checkHit("flushIdleMiss", 1'b0);
        applyStimulus(0, 32'h000, 0, 0, 32'h0, 1);
        checkReq("flushNoRefill", 1'b0);
        applyStimulus(1, 32'h100, 0, 0, 32'h0, 1);
        checkHit("flushCleared100", 1'b0);

        // Flush on beat 2 of the refill: refill completes but installs nothing.
        applyStimulus(0, 32'h000, 0, 1, 32'hE0, 1);
        checkReq("discardBeat0", 1'b1);
        checkOutput("discardBeat0 memAddr", cacheBus.memAddr, 32'h100);
        applyStimulus(0, 32'h000, 0, 1, 32'hE1, 1);
        applyStimulus(0, 32'h000, 1, 1, 32'hE2, 1);
        applyStimulus(0, 32'h000, 0, 1, 32'hE3, 1);
        checkReq("discardBeat3", 1'b1);
        applyStimulus(1, 32'h100, 0, 0, 32'h0, 1);
        checkHit("discardNoInstall", 1'b0);
        checkReq("discardBackIdle", 1'b0);

        // rdyIn stall of three cycles with a beat held on the bus.
        applyStimulus(0, 32'h000, 0, 1, 32'hF0, 1);
        checkReq("stallBeat0", 1'b1);
        applyStimulus(0, 32'h000, 0, 1, 32'hF1, 1);
        for (int s = 0; s < 3; s++) begin
            applyStimulus(0, 32'h000, 0, 1, 32'hF2, 0);
            checkReq($sformatf("stall%0d", s), 1'b1);
            checkOutput($sformatf("stall%0d memAddr", s), cacheBus.memAddr, 32'h100);
        end
        applyStimulus(0, 32'h000, 0, 1, 32'hF2, 1);
        applyStimulus(0, 32'h000, 0, 1, 32'hF3, 1);
        for (int w = 0; w < 4; w++) begin
            applyStimulus(1, 32'h100 + 32'(w * 4), 0, 0, 32'h0, 1);
            checkHit($sformatf("stallWord%0d", w), 1'b1);
            checkOutput($sformatf("stallWord%0d dataOut", w), cacheBus.dataOut, 32'hF0 + 32'(w));
        end

        // Asynchronous reset in the middle of a refill of 0x600.
        applyStimulus(1, 32'h600, 0, 0, 32'h0, 1);
        checkHit("resetMiss600", 1'b0);
        applyStimulus(0, 32'h000, 0, 1, 32'hC6, 1);
        checkReq("resetBeat0", 1'b1);
        applyStimulus(0, 32'h000, 0, 1, 32'hC7, 1);
        @(negedge clkIn);
        cacheBus.memValid = 1'b0;
        #2;
        rstIn = 1'b0;
        #1;
        checkReq("asyncReset", 1'b0);
        checkOutput("asyncReset memAddr", cacheBus.memAddr, 32'h0);
        @(negedge clkIn);
        rstIn = 1'b1;
        applyStimulus(1, 32'h100, 0, 0, 32'h0, 1);
        checkHit("postReset100", 1'b0);
        applyStimulus(0, 32'h000, 0, 1, 32'h60, 1);
        checkReq("postResetRefill", 1'b1);
        applyStimulus(0, 32'h000, 0, 1, 32'h61, 1);
        applyStimulus(0, 32'h000, 0, 1, 32'h62, 1);
        applyStimulus(0, 32'h000, 0, 1, 32'h63, 1);
        applyStimulus(1, 32'h100, 0, 0, 32'h0, 1);
        checkHit("postResetFill100", 1'b1);
        checkOutput("postResetFill100 dataOut", cacheBus.dataOut, 32'h60);
        applyStimulus(1, 32'h600, 0, 0, 32'h0, 1);
        checkHit("postReset600", 1'b0);

        @(negedge clkIn);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/inst_cache_assoc.md
INST_CACHE_ASSOC -- requirements
Module: inst_cache_assoc

Interface
REQ-001 SHALL have parameter INDEX_WIDTH, default 6, meaning log2 of the number of sets.
REQ-002 SHALL have parameter WAYS, default 2, meaning associativity; legal values are 1 and 2.
REQ-003 SHALL have parameter LINE_WORDS, default 4, meaning 32-bit words per line; legal values are powers of 2 from 1 to 16.
REQ-004 SHALL have port clkIn, input, 1, the single clock, rising edge.
REQ-005 SHALL have port rstIn, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port rdyIn, input, 1, global enable; all state is frozen while rdyIn is low.
REQ-007 SHALL have port fetchValid, input, 1, fetch request present.
REQ-008 SHALL have port addrIn, input, 32, fetch PC; bits [1:0] are ignored.
REQ-009 SHALL have port hit, output, 1, dataOut is valid this cycle.
REQ-010 SHALL have port dataOut, output, 32, fetched instruction.
REQ-011 SHALL have port flush, input, 1, invalidate the whole cache (fence.i).
REQ-012 SHALL have port memReq, output, 1, level request for a line refill.
REQ-013 SHALL have port memAddr, output, 32, line base address, with the low log2(LINE_WORDS)+2 bits equal to zero.
REQ-014 SHALL have port memValid, input, 1, one refill beat is present.
REQ-015 SHALL have port memData, input, 32, refill beat data, in ascending word order.

Function
REQ-016 SHALL split addrIn into offset [OFF+1:2], index [INDEX_WIDTH+OFF+1:OFF+2] and tag (the remaining upper bits), where OFF = log2(LINE_WORDS).
REQ-017 SHALL assert hit combinationally when the FSM is in IDLE, fetchValid is 1, and a valid way of the indexed set has a matching tag.
REQ-018 SHALL drive dataOut with the offset word of the hitting way; when hit is 0, dataOut is don't-care.
REQ-019 SHALL use FSM states IDLE and REFILL.
REQ-020 SHALL go from IDLE to REFILL on a clock edge with rdyIn=1, fetchValid=1, hit=0 and flush=0; on that edge it latches the line base address and the victim way.
REQ-021 SHALL, in REFILL, hold memReq=1 and memAddr constant, and hold hit=0.
REQ-022 SHALL, in REFILL, on each edge with rdyIn=1 and memValid=1, store memData into the refill buffer at word counter position and increment the counter.
REQ-023 SHALL, on the beat where the counter equals LINE_WORDS-1, write the line, tag and valid bit, update LRU, drop memReq, and return to IDLE; the following cycle is a hit.
REQ-024 SHALL choose the victim as the lowest-numbered invalid way, otherwise the LRU way.
REQ-025 SHALL use one LRU bit per set when WAYS=2, updated on every hit or fill to point at the other way; no LRU state exists when WAYS=1.
REQ-026 SHALL, on flush in IDLE, clear all valid bits in one edge; a simultaneous miss does not start a refill.
REQ-027 SHALL, on flush in REFILL, set a discard flag; the refill continues to its last beat, installs nothing, and the FSM returns to IDLE.
REQ-028 SHALL ignore memValid while in IDLE.
REQ-029 SHALL leave all registers unchanged on any edge with rdyIn=0, including memValid beats, which the memory side holds until rdyIn=1.

Reset
REQ-030 SHALL, on rstIn=0 and asynchronously: FSM=IDLE, all valid bits=0, LRU=0, word counter=0, discard flag=0, memReq=0, memAddr=0, hit=0.
REQ-031 SHALL not reset the data and tag arrays.
REQ-032 SHALL, on reset mid-REFILL, abandon the refill with no line installed.

Structure
REQ-033 SHALL place the FSM state encoding and the OFF and TAG_WIDTH derivation functions in shared package cpu_pkg.
REQ-034 SHALL implement one way's tag, valid and data storage as sub-module icache_way, instantiated WAYS times.

Verification
Bench parameters: INDEX_WIDTH=4, WAYS=2, LINE_WORDS=4.
REQ-035 SHALL cover cold miss: fetch 0x100 -> memReq=1, memAddr=0x100; 4 beats 0xA0..0xA3 -> 0x108 hits with 0xA2 on the cycle after the last beat.
REQ-036 SHALL cover two-way conflict: fill 0x100 and 0x500, hit 0x100, miss 0x900 -> 0x500 evicted, 0x100 still hits.
REQ-037 SHALL cover flush during REFILL: flush on beat 2 -> no install, next fetch of 0x100 misses again.
REQ-038 SHALL cover rdyIn stall: rdyIn=0 for 3 cycles mid-refill with memValid held -> identical beat sequence, correct data installed.
REQ-039 SHALL cover asynchronous reset asserted mid-REFILL -> memReq=0 immediately and all fetches miss afterwards.
